pri_enc: RTL and testbench
==========================

Name: pri_enc

Overview:
- Parameterised 4-input, N-bit registered selector.
- The 2-bit sel chooses one of four data words (a, b, c, d). The chosen word is driven on out after one clock.
- Used as a small datapath steering element. sel encodes priority/source index; index 0 is the highest-priority source (a).

Parameters:
- N, 8, data width of each input word and of out (N >= 1).

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- a  input  N  source word, selected when sel = 0.
- b  input  N  source word, selected when sel = 1.
- c  input  N  source word, selected when sel = 2.
- d  input  N  source word, selected when sel = 3.
- sel  input  2  source index.
- out  output  N  registered selected word.

Behaviour:
- Clocking and reset:
  - One clock (clk). Reset is synchronous and active-high (rst).
  - Reset is sampled only on the rising edge of clk.
  - While rst = 1 at a rising edge, out <= 0. Reset has priority over all other inputs.
- Normal operation, on each rising edge with rst = 0:
  - sel = 0 -> out <= a
  - sel = 1 -> out <= b
  - sel = 2 -> out <= c
  - sel = 3 -> out <= d
- Latency:
  - Exactly 1 cycle. out reflects the sel/data values sampled at the previous rising edge.
  - out holds steady between edges. No combinational path from any input to out.
- Full throughput: a new selection is accepted every cycle. No handshake, no stall.
- Width rules:
  - Data is passed bit-exact. No sign extension, truncation or arithmetic.
  - All four inputs and out are exactly N bits.
- X/unknown sel: not defined for synthesis. The RTL must use a full case with a default (default -> d) so no latch is inferred.
- Boundary conditions:
  - sel changing every cycle: each cycle's output follows the previous cycle's sel.
  - Data changing in the same cycle as sel: the word sampled at the edge is used.
  - Reset asserted mid-stream: out is 0 on the edge where rst = 1, and remains 0 while rst stays high.
  - Reset deasserted: the first edge with rst = 0 loads the selected word.
  - Identical a/b/c/d values: out is unchanged across sel changes.
  - N = 1 must work.

Decomposition:
- Shared package holds:
  - SEL_W = 2
  - source-index constants SEL_A = 0, SEL_B = 1, SEL_C = 2, SEL_D = 3
- A combinational sub-module pri_enc_mux4 (4:1, N-bit, case on sel) is natural.
- The top pri_enc adds only the output register and reset.

Test Plan:
- Reset: rst = 1 for 2 cycles with a = 0x24, b = 0x81, c = 0x09, d = 0x63, sel = 2 -> out = 0x00 on both edges.
- Sweep: rst = 0, same data, sel stepped 0, 1, 2, 3 one per cycle -> out = 0x24, 0x81, 0x09, 0x63, each one cycle after the corresponding sel.
- Data change with sel held: sel = 1, b changes 0x81 -> 0xFF -> out = 0xFF one cycle after the change; a, c, d changes do not affect out.
- Mid-stream reset: sweeping sel 0..3, assert rst for one cycle at sel = 2.
  - out = 0x00 for that cycle.
  - Next cycle out = 0x63 (sel = 3).
- Extremes: a = 0x00, b = 0xFF, c = 0xAA, d = 0x55, sel toggled 1 -> 2 -> 3 -> 0 every cycle -> out = 0xFF, 0xAA, 0x55, 0x00 with 1-cycle latency.
- Width: instantiate with N = 1 and N = 16; repeat the sweep with N = 16 values 0x1234, 0xBEEF, 0x0001, 0x8000 -> bit-exact outputs.

Source files
------------

// File: rtl/pri_enc_pkg.sv
// pri_enc shared definitions.
// Select width and source-index encodings.
package pri_enc_pkg;

  localparam int SEL_W = 2;

  typedef logic [SEL_W-1:0] sel_t;

  localparam sel_t SEL_A = 2'd0;
  localparam sel_t SEL_B = 2'd1;
  localparam sel_t SEL_C = 2'd2;
  localparam sel_t SEL_D = 2'd3;

endpackage

// File: rtl/pri_enc_mux4.sv
// pri_enc_mux4: combinational 4:1 N-bit word selector.
// Index 0 (a) is the highest-priority source.
module pri_enc_mux4
  import pri_enc_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] c,
  input  logic [N-1:0] d,
  input  sel_t         sel,
  output logic [N-1:0] y
);

  // Unknown sel falls through to d so no latch is ever inferred.
  always_comb begin
    y = d;
    case (sel)
      SEL_A:   y = a;
      SEL_B:   y = b;
      SEL_C:   y = c;
      default: y = d;
    endcase
  end

endmodule

// File: rtl/pri_enc.sv
// pri_enc: registered 4-input N-bit selector.
// One-cycle latency, synchronous active-high reset.
module pri_enc
  import pri_enc_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] c,
  input  logic [N-1:0] d,
  input  sel_t         sel,
  output logic [N-1:0] out
);

  logic [N-1:0] out_d;
  logic [N-1:0] out_q;

  pri_enc_mux4 #(
    .N(N)
  ) u_mux (
    .a  (a),
    .b  (b),
    .c  (c),
    .d  (d),
    .sel(sel),
    .y  (out_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_pri_enc.sv
// tb_pri_enc: scoreboard bench for pri_enc at N = 8, 16 and 1.
// Stimulus pushes hand-computed words; a monitor pops after each edge.
module tb_pri_enc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [7:0]  a8 = '0, b8 = '0, c8 = '0, d8 = '0;
  logic [1:0]  s8 = '0;
  logic [7:0]  o8;

  logic [15:0] a16 = '0, b16 = '0, c16 = '0, d16 = '0;
  logic [1:0]  s16 = '0;
  logic [15:0] o16;

  logic        a1 = '0, b1 = '0, c1 = '0, d1 = '0;
  logic [1:0]  s1 = '0;
  logic        o1;

  logic [7:0]  q8[$];
  logic [15:0] q16[$];
  logic        q1[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pri_enc #(.N(8)) dut8 (
    .clk(clk), .rst(rst),
    .a(a8), .b(b8), .c(c8), .d(d8),
    .sel(s8), .out(o8)
  );

  pri_enc #(.N(16)) dut16 (
    .clk(clk), .rst(rst),
    .a(a16), .b(b16), .c(c16), .d(d16),
    .sel(s16), .out(o16)
  );

  pri_enc #(.N(1)) dut1 (
    .clk(clk), .rst(rst),
    .a(a1), .b(b1), .c(c1), .d(d1),
    .sel(s1), .out(o1)
  );

  // Monitor: each edge consumes at most one expected word per instance.
  always @(posedge clk) begin
    #1;
    if (q8.size() != 0) begin
      logic [7:0] e8;
      e8 = q8.pop_front();
      checks++;
      if (o8 !== e8) begin
        errors++;
        $display("FAIL out8 t=%0t got %h expected %h", $time, o8, e8);
      end
    end
    if (q16.size() != 0) begin
      logic [15:0] e16;
      e16 = q16.pop_front();
      checks++;
      if (o16 !== e16) begin
        errors++;
        $display("FAIL out16 t=%0t got %h expected %h", $time, o16, e16);
      end
    end
    if (q1.size() != 0) begin
      logic e1;
      e1 = q1.pop_front();
      checks++;
      if (o1 !== e1) begin
        errors++;
        $display("FAIL out1 t=%0t got %b expected %b", $time, o1, e1);
      end
    end
  end

  task automatic step8(input logic r, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] c,
                       input logic [7:0] d, input logic [1:0] s,
                       input logic [7:0] exp);
    @(negedge clk);
    rst = r;
    a8 = a; b8 = b; c8 = c; d8 = d; s8 = s;
    q8.push_back(exp);
  endtask

  task automatic step16(input logic r, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] c,
                        input logic [15:0] d, input logic [1:0] s,
                        input logic [15:0] exp);
    @(negedge clk);
    rst = r;
    a16 = a; b16 = b; c16 = c; d16 = d; s16 = s;
    q16.push_back(exp);
  endtask

  task automatic step1(input logic r, input logic a, input logic b,
                       input logic c, input logic d,
                       input logic [1:0] s, input logic exp);
    @(negedge clk);
    rst = r;
    a1 = a; b1 = b; c1 = c; d1 = d; s1 = s;
    q1.push_back(exp);
  endtask

  // Reset on all three instances with nonzero data presented.
  task automatic step_rst_all();
    @(negedge clk);
    rst = 1'b1;
    a8 = 8'h24; b8 = 8'h81; c8 = 8'h09; d8 = 8'h63; s8 = 2'd2;
    a16 = 16'hFFFF; b16 = 16'hFFFF; c16 = 16'hFFFF;
    d16 = 16'hFFFF; s16 = 2'd3;
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b1; d1 = 1'b1; s1 = 2'd1;
    q8.push_back(8'h00);
    q16.push_back(16'h0000);
    q1.push_back(1'b0);
  endtask

  initial begin
    step_rst_all();
    step_rst_all();

    // sweep
    step8(0, 8'h24, 8'h81, 8'h09, 8'h63, 2'd0, 8'h24);
    step8(0, 8'h24, 8'h81, 8'h09, 8'h63, 2'd1, 8'h81);
    step8(0, 8'h24, 8'h81, 8'h09, 8'h63, 2'd2, 8'h09);
    step8(0, 8'h24, 8'h81, 8'h09, 8'h63, 2'd3, 8'h63);

    // data change with sel held at 1
    step8(0, 8'h24, 8'h81, 8'h09, 8'h63, 2'd1, 8'h81);
    step8(0, 8'h24, 8'hFF, 8'h09, 8'h63, 2'd1, 8'hFF);
    step8(0, 8'h11, 8'hFF, 8'h09, 8'h63, 2'd1, 8'hFF);
    step8(0, 8'h11, 8'hFF, 8'h22, 8'h63, 2'd1, 8'hFF);
    step8(0, 8'h11, 8'hFF, 8'h22, 8'h33, 2'd1, 8'hFF);

    // mid-stream reset at sel = 2
    step8(0, 8'h24, 8'h81, 8'h09, 8'h63, 2'd0, 8'h24);
    step8(0, 8'h24, 8'h81, 8'h09, 8'h63, 2'd1, 8'h81);
    step8(1, 8'h24, 8'h81, 8'h09, 8'h63, 2'd2, 8'h00);
    step8(0, 8'h24, 8'h81, 8'h09, 8'h63, 2'd3, 8'h63);

    // held reset, then release loads on first edge
    step8(1, 8'h24, 8'h81, 8'h09, 8'h63, 2'd0, 8'h00);
    step8(1, 8'h24, 8'h81, 8'h09, 8'h63, 2'd3, 8'h00);
    step8(0, 8'h24, 8'h81, 8'h09, 8'h63, 2'd1, 8'h81);

    // extremes, sel toggling every cycle
    step8(0, 8'h00, 8'hFF, 8'hAA, 8'h55, 2'd1, 8'hFF);
    step8(0, 8'h00, 8'hFF, 8'hAA, 8'h55, 2'd2, 8'hAA);
    step8(0, 8'h00, 8'hFF, 8'hAA, 8'h55, 2'd3, 8'h55);
    step8(0, 8'h00, 8'hFF, 8'hAA, 8'h55, 2'd0, 8'h00);

    // data and sel change together
    step8(0, 8'h3C, 8'hC3, 8'h0F, 8'hF0, 2'd2, 8'h0F);

    // identical sources
    step8(0, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 2'd0, 8'h5A);
    step8(0, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 2'd3, 8'h5A);
    step8(0, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 2'd1, 8'h5A);

    // N = 16 sweep
    step16(0, 16'h1234, 16'hBEEF, 16'h0001, 16'h8000, 2'd0, 16'h1234);
    step16(0, 16'h1234, 16'hBEEF, 16'h0001, 16'h8000, 2'd1, 16'hBEEF);
    step16(0, 16'h1234, 16'hBEEF, 16'h0001, 16'h8000, 2'd2, 16'h0001);
    step16(0, 16'h1234, 16'hBEEF, 16'h0001, 16'h8000, 2'd3, 16'h8000);

    // N = 1 sweep
    step1(0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1);
    step1(0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0);
    step1(0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 1'b1);
    step1(0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd3, 1'b0);
    step1(0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b1);

    // drain with a bounded wait
    repeat (4) @(posedge clk);
    #2;
    checks++;
    if (q8.size() + q16.size() + q1.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d expected 0",
               q8.size() + q16.size() + q1.size());
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
